// File: rtl/calc_pkg.sv
// Shared types for the RPN calculator: opcode and FSM state enums plus operand-count rules.
package calc_pkg;

   typedef enum logic [2:0] {
      OP_MUL  = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_SQR  = 3'd3,
      OP_INC2 = 3'd4,
      OP_DEC2 = 3'd5,
      OP_SWAP = 3'd6,
      OP_CLR  = 3'd7
   } calc_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ERR  = 1'b1
   } calc_state_e;

   localparam logic [1:0] ARITY_BINARY = 2'd2;
   localparam logic [1:0] ARITY_UNARY  = 2'd1;
   localparam logic [1:0] ARITY_NONE   = 2'd0;

   // Minimum stack depth an operator needs before it may execute.
   function automatic logic [1:0] op_min_count(calc_op_e op);
      case (op)
         OP_MUL, OP_ADD, OP_SUB, OP_SWAP: op_min_count = ARITY_BINARY;
         OP_SQR, OP_INC2, OP_DEC2:        op_min_count = ARITY_UNARY;
         default:                         op_min_count = ARITY_NONE;
      endcase
   endfunction

   function automatic logic is_binary(calc_op_e op);
      is_binary = (op == OP_MUL) || (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/rpn_calc_if.sv
// Front-end bus of the RPN calculator: one-button entry inputs and the display/status outputs.
interface rpn_calc_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   // Handshake: there is no ready; an entry commits on the cycle validIn rises
   // (high now, low last cycle), with opIn/dataIn sampled in that same cycle.
   // Edges must be at least two cycles apart; holding validIn high commits once.
   logic             validIn;
   logic             opIn;
   logic [WIDTH-1:0] dataIn;
   logic [WIDTH-1:0] dataOut;
   logic [CW-1:0]    count;
   logic             err;
   logic             ovf;

   modport master (output validIn, opIn, dataIn, input dataOut, count, err, ovf);
   modport slave  (input validIn, opIn, dataIn, output dataOut, count, err, ovf);
endinterface

// File: rtl/calc_alu.sv
// Combinational ALU: a = next-on-stack, b = top-of-stack. Define RPN_CALC_SAT_EN to clamp instead of wrap.
module calc_alu
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  calc_op_e         op,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);
   localparam int W2 = 2 * WIDTH;

   logic [W2-1:0] full;
   logic          hi;
   logic          lo;

   always_comb begin
      full = '0;
      hi   = 1'b0;
      lo   = 1'b0;
      case (op)
         OP_MUL: begin
            full = W2'(a) * W2'(b);
            hi   = |full[W2-1:WIDTH];
         end
         OP_SQR: begin
            full = W2'(b) * W2'(b);
            hi   = |full[W2-1:WIDTH];
         end
         OP_ADD: begin
            full = W2'({1'b0, a} + {1'b0, b});
            hi   = full[WIDTH];
         end
         OP_INC2: begin
            full = W2'({1'b0, b} + (WIDTH + 1)'(2));
            hi   = full[WIDTH];
         end
         OP_SUB: begin
            full = W2'(a - b);
            lo   = (a < b);
         end
         OP_DEC2: begin
            full = W2'(b - WIDTH'(2));
            lo   = (b < WIDTH'(2));
         end
         default: full = W2'(b);
      endcase
   end

   always_comb begin
      ovf    = hi | lo;
      result = full[WIDTH-1:0];
`ifdef RPN_CALC_SAT_EN
      if (hi)      result = '1;
      else if (lo) result = '0;
`endif
   end

endmodule

// File: rtl/rpn_calc.sv
// RPN calculator top: entry edge detect, IDLE/ERR FSM, operand stack, depth and status registers.
module rpn_calc
   import calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   rpn_calc_if.slave   bus,
   output calc_state_e state_dbg
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic             valid_d;
   logic             commit;
   calc_op_e         op;
   calc_state_e      state, state_n;
   logic [WIDTH-1:0] stack   [DEPTH];
   logic [WIDTH-1:0] stack_n [DEPTH];
   logic [CW-1:0]    count_r, count_n;
   logic [WIDTH-1:0] dout_r, dout_n;
   logic             err_r, err_n, ovf_r, ovf_n;
   logic [IW-1:0]    tos_idx, nos_idx, push_idx;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   assign commit   = bus.validIn & ~valid_d;
   assign op       = calc_op_e'(bus.dataIn[2:0]);
   // Indices are only used when count guarantees they are in range.
   assign tos_idx  = IW'(count_r - CW'(1));
   assign nos_idx  = IW'(count_r - CW'(2));
   assign push_idx = IW'(count_r);

   calc_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (stack[nos_idx]),
      .b      (stack[tos_idx]),
      .op     (op),
      .result (alu_res),
      .ovf    (alu_ovf)
   );

   always_comb begin
      state_n = state;
      stack_n = stack;
      count_n = count_r;
      err_n   = err_r;
      ovf_n   = ovf_r;
      if (commit) begin
         if (bus.opIn && op == OP_CLR) begin
            count_n = '0;
            err_n   = 1'b0;
            ovf_n   = 1'b0;
            state_n = ST_IDLE;
         end else if (state == ST_IDLE) begin
            if (!bus.opIn) begin
               if (count_r == FULL) begin
                  err_n   = 1'b1;
                  state_n = ST_ERR;
               end else begin
                  stack_n[push_idx] = bus.dataIn;
                  count_n           = count_r + CW'(1);
               end
            end else if (count_r < CW'(op_min_count(op))) begin
               err_n   = 1'b1;
               state_n = ST_ERR;
            end else if (op == OP_SWAP) begin
               stack_n[tos_idx] = stack[nos_idx];
               stack_n[nos_idx] = stack[tos_idx];
            end else if (is_binary(op)) begin
               stack_n[nos_idx] = alu_res;
               count_n          = count_r - CW'(1);
               ovf_n            = alu_ovf;
            end else begin
               stack_n[tos_idx] = alu_res;
               ovf_n            = alu_ovf;
            end
         end
      end
      dout_n = (count_n == '0) ? '0 : stack_n[IW'(count_n - CW'(1))];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         count_r <= '0;
         dout_r  <= '0;
         err_r   <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         state   <= state_n;
         count_r <= count_n;
         dout_r  <= dout_n;
         err_r   <= err_n;
         ovf_r   <= ovf_n;
      end
   end

   // The edge detector keeps tracking through reset so a held button cannot commit on release.
   always_ff @(posedge clk) begin
      valid_d <= bus.validIn;
   end

   always_ff @(posedge clk) begin
      stack <= stack_n;
   end

   assign bus.dataOut = dout_r;
   assign bus.count   = count_r;
   assign bus.err     = err_r;
   assign bus.ovf     = ovf_r;
   assign state_dbg   = state;

endmodule

// File: tb/tb_rpn_calc.sv
// Directed bench for rpn_calc (WIDTH=8, DEPTH=4); expectations follow RPN_CALC_SAT_EN when defined.
module tb_rpn_calc;
   import calc_pkg::*;

   logic        clk;
   logic        rst;
   calc_state_e state_dbg;
   int          errors;
   int          checks;

   rpn_calc_if #(.WIDTH(8), .DEPTH(4)) bus ();

   rpn_calc #(.WIDTH(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

`ifdef RPN_CALC_SAT_EN
   localparam logic [7:0] EXP_ADD   = 8'd255;
   localparam logic [7:0] EXP_SUB   = 8'd0;
   localparam logic [7:0] EXP_SQR16 = 8'd255;
   localparam logic [7:0] EXP_DEC   = 8'd0;
`else
   localparam logic [7:0] EXP_ADD   = 8'd44;
   localparam logic [7:0] EXP_SUB   = 8'd252;
   localparam logic [7:0] EXP_SQR16 = 8'd0;
   localparam logic [7:0] EXP_DEC   = 8'd255;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One entry: rising edge in one cycle, low the next; returns at a negedge with outputs settled.
   task automatic enter(input logic is_op, input logic [7:0] data);
      @(negedge clk);
      bus.validIn = 1'b1;
      bus.opIn    = is_op;
      bus.dataIn  = data;
      @(negedge clk);
      bus.validIn = 1'b0;
   endtask

   task automatic push(input logic [7:0] v);
      enter(1'b0, v);
   endtask

   task automatic oper(input calc_op_e o);
      enter(1'b1, {5'd0, o});
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.validIn = 1'b0;
      bus.opIn    = 1'b0;
      bus.dataIn  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.dataOut !== 8'd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", bus.dataOut); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
      checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE); end
   endtask

   task automatic test_mul();
      push(8'd5);
      push(8'd3);
      checks++; if (bus.dataOut !== 8'd3 || bus.count !== 3'd2) begin errors++; $display("FAIL push_tos: got dout=%0d count=%0d expected 3/2", bus.dataOut, bus.count); end
      oper(OP_MUL);
      checks++; if (bus.dataOut !== 8'd15) begin errors++; $display("FAIL mul_dout: got %0d expected 15", bus.dataOut); end
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL mul_count: got %0d expected 1", bus.count); end
      checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL mul_ovf: got %b expected 0", bus.ovf); end
      oper(OP_CLR);
   endtask

   task automatic test_add_ovf();
      push(8'd200);
      push(8'd100);
      oper(OP_ADD);
      checks++; if (bus.dataOut !== EXP_ADD) begin errors++; $display("FAIL add_dout: got %0d expected %0d", bus.dataOut, EXP_ADD); end
      checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL add_ovf: got %b expected 1", bus.ovf); end
      checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL add_count: got %0d expected 1", bus.count); end
      oper(OP_CLR);
   endtask

   task automatic test_sub_swap();
      push(8'd3);
      push(8'd7);
      oper(OP_SUB);
      checks++; if (bus.dataOut !== EXP_SUB || bus.ovf !== 1'b1) begin errors++; $display("FAIL sub: got dout=%0d ovf=%b expected %0d/1", bus.dataOut, bus.ovf, EXP_SUB); end
      push(8'd1);
      oper(OP_SWAP);
      checks++; if (bus.dataOut !== EXP_SUB || bus.count !== 3'd2) begin errors++; $display("FAIL swap: got dout=%0d count=%0d expected %0d/2", bus.dataOut, bus.count, EXP_SUB); end
      checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL swap_ovf_kept: got %b expected 1", bus.ovf); end
      oper(OP_ADD);
      checks++; if (bus.dataOut !== EXP_SUB + 8'd1) begin errors++; $display("FAIL swap_then_add: got %0d expected %0d", bus.dataOut, EXP_SUB + 8'd1); end
      oper(OP_CLR);
   endtask

   task automatic test_unary();
      push(8'd15);
      oper(OP_SQR);
      checks++; if (bus.dataOut !== 8'd225 || bus.ovf !== 1'b0) begin errors++; $display("FAIL sqr: got dout=%0d ovf=%b expected 225/0", bus.dataOut, bus.ovf); end
      oper(OP_INC2);
      checks++; if (bus.dataOut !== 8'd227 || bus.count !== 3'd1) begin errors++; $display("FAIL inc2: got dout=%0d count=%0d expected 227/1", bus.dataOut, bus.count); end
      oper(OP_DEC2);
      oper(OP_DEC2);
      checks++; if (bus.dataOut !== 8'd223) begin errors++; $display("FAIL dec2: got %0d expected 223", bus.dataOut); end
      push(8'd16);
      oper(OP_SQR);
      checks++; if (bus.dataOut !== EXP_SQR16 || bus.ovf !== 1'b1) begin errors++; $display("FAIL sqr_ovf: got dout=%0d ovf=%b expected %0d/1", bus.dataOut, bus.ovf, EXP_SQR16); end
      push(8'd1);
      oper(OP_DEC2);
      checks++; if (bus.dataOut !== EXP_DEC || bus.ovf !== 1'b1 || bus.count !== 3'd3) begin errors++; $display("FAIL dec2_under: got dout=%0d ovf=%b count=%0d expected %0d/1/3", bus.dataOut, bus.ovf, bus.count, EXP_DEC); end
      oper(OP_CLR);
   endtask

   task automatic test_overflow();
      push(8'd1);
      push(8'd2);
      push(8'd3);
      push(8'd4);
      checks++; if (bus.count !== 3'd4 || bus.err !== 1'b0) begin errors++; $display("FAIL full: got count=%0d err=%b expected 4/0", bus.count, bus.err); end
      push(8'd9);
      checks++; if (bus.err !== 1'b1 || bus.count !== 3'd4 || bus.dataOut !== 8'd4) begin errors++; $display("FAIL push_ovf: got err=%b count=%0d dout=%0d expected 1/4/4", bus.err, bus.count, bus.dataOut); end
      checks++; if (state_dbg !== ST_ERR) begin errors++; $display("FAIL err_state: got %0d expected %0d", state_dbg, ST_ERR); end
      oper(OP_ADD);
      checks++; if (bus.dataOut !== 8'd4 || bus.count !== 3'd4 || bus.err !== 1'b1) begin errors++; $display("FAIL err_ignore: got dout=%0d count=%0d err=%b expected 4/4/1", bus.dataOut, bus.count, bus.err); end
      oper(OP_CLR);
      checks++; if (bus.count !== 3'd0 || bus.err !== 1'b0 || bus.dataOut !== 8'd0 || state_dbg !== ST_IDLE) begin errors++; $display("FAIL clr: got count=%0d err=%b dout=%0d state=%0d expected 0/0/0/0", bus.count, bus.err, bus.dataOut, state_dbg); end
   endtask

   task automatic test_underflow_hold();
      oper(OP_INC2);
      checks++; if (bus.err !== 1'b1 || bus.count !== 3'd0 || bus.dataOut !== 8'd0) begin errors++; $display("FAIL inc2_empty: got err=%b count=%0d dout=%0d expected 1/0/0", bus.err, bus.count, bus.dataOut); end
      oper(OP_CLR);
      push(8'd8);
      oper(OP_SUB);
      checks++; if (bus.err !== 1'b1 || bus.count !== 3'd1 || bus.dataOut !== 8'd8) begin errors++; $display("FAIL sub_one: got err=%b count=%0d dout=%0d expected 1/1/8", bus.err, bus.count, bus.dataOut); end
      oper(OP_CLR);
      @(negedge clk);
      bus.validIn = 1'b1;
      bus.opIn    = 1'b0;
      bus.dataIn  = 8'd42;
      repeat (10) @(negedge clk);
      bus.validIn = 1'b0;
      @(negedge clk);
      checks++; if (bus.count !== 3'd1 || bus.dataOut !== 8'd42) begin errors++; $display("FAIL hold_one_commit: got count=%0d dout=%0d expected 1/42", bus.count, bus.dataOut); end
   endtask

   task automatic test_reset_commit();
      push(8'd77);
      @(negedge clk);
      rst         = 1'b1;
      bus.validIn = 1'b1;
      bus.opIn    = 1'b0;
      bus.dataIn  = 8'd5;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.count !== 3'd0 || bus.dataOut !== 8'd0 || bus.err !== 1'b0 || bus.ovf !== 1'b0) begin errors++; $display("FAIL rst_wins: got count=%0d dout=%0d err=%b ovf=%b expected all 0", bus.count, bus.dataOut, bus.err, bus.ovf); end
      repeat (3) @(negedge clk);
      checks++; if (bus.count !== 3'd0 || bus.dataOut !== 8'd0) begin errors++; $display("FAIL held_release: got count=%0d dout=%0d expected 0/0", bus.count, bus.dataOut); end
      bus.validIn = 1'b0;
      @(negedge clk);
      push(8'd6);
      checks++; if (bus.count !== 3'd1 || bus.dataOut !== 8'd6) begin errors++; $display("FAIL after_release: got count=%0d dout=%0d expected 1/6", bus.count, bus.dataOut); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_mul();
      test_add_ovf();
      test_sub_swap();
      test_unary();
      test_overflow();
      test_underflow_hold();
      test_reset_commit();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
